// File: rtl/vend_pkg.sv
// Shared types for the vend credit controller.
//   state_t : controller phase (ACCEPT, VEND, REFUND)
//   coin_t  : coin slot code as presented on the coin input
package vend_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        VEND   = 2'd1,
        REFUND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_1    = 2'd1,
        COIN_2    = 2'd2,
        COIN_3    = 2'd3
    } coin_t;

endpackage

// File: rtl/vend_drop_timer.sv
// Loadable down-counter that times the drop pulse.
//   clock, reset : clock, async active-high reset
//   i_load       : load DROP_CYCLES (first VEND cycle follows)
//   o_done_c     : combinational, high in the last cycle of the drop pulse
module vend_drop_timer #(
    parameter int unsigned DROP_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    output logic o_done_c
);

    localparam int unsigned CNT_W = $clog2(DROP_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Holds the number of drop cycles remaining, including the current one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(DROP_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-accepting vend controller with configurable price/coin values,
// overpay carry-over, over-limit reject, cancel/refund handshake and vend counter.
//   clock, reset              : clock, async active-high reset
//   coin_valid, coin          : coin strobe and code (00 = none)
//   cancel, refund_ack        : refund request (level) and refund acceptance
//   credit                    : credit held
//   drop                      : high while an item is dispensed
//   coin_reject               : one-cycle pulse, sampled coin not credited
//   refund_valid/amount       : pending refund and its value
//   vend_count                : total vends, wrapping
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned PRICE       = 4,
    parameter int unsigned MAX_CREDIT  = 15,
    parameter int unsigned VAL1        = 1,
    parameter int unsigned VAL2        = 3,
    parameter int unsigned VAL3        = 5,
    parameter int unsigned DROP_CYCLES = 3,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                refund_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                drop,
    output logic                coin_reject,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount,
    output logic [COUNT_W-1:0]  vend_count
);

    // Two spare bits so credit plus the largest coin never overflows.
    localparam int unsigned SUM_W = CREDIT_W + 2;
    localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT);

    generate
        if (PRICE < 1 || PRICE > MAX_CREDIT) begin : g_bad_price
            $error("vend_credit_fsm: PRICE must satisfy 1 <= PRICE <= MAX_CREDIT");
        end
        if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
            $error("vend_credit_fsm: MAX_CREDIT must be < 2**CREDIT_W");
        end
        if (DROP_CYCLES < 1) begin : g_bad_drop
            $error("vend_credit_fsm: DROP_CYCLES must be >= 1");
        end
    endgenerate

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_refund_amount;
    logic                r_drop;
    logic                r_coin_reject;
    logic                r_refund_valid;
    logic [COUNT_W-1:0]  r_vend_count;

    logic [SUM_W-1:0]    w_val;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_eff;
    logic                w_sampled;
    logic                w_over;
    logic                w_cancel;
    logic                w_vend;
    logic                w_timer_done;

    // Coin code to credit value.
    always_comb begin
        w_val = '0;
        case (coin_t'(coin))
            COIN_1:  w_val = SUM_W'(VAL1);
            COIN_2:  w_val = SUM_W'(VAL2);
            COIN_3:  w_val = SUM_W'(VAL3);
            default: w_val = '0;
        endcase
    end

    assign w_sampled = coin_valid && (coin != 2'b00);
    assign w_sum     = SUM_W'(r_credit) + w_val;
    assign w_over    = w_sampled && (w_sum > MAX_S);
    assign w_eff     = (w_sampled && !w_over) ? w_sum : SUM_W'(r_credit);
    // Cancel with nothing held is treated as if it were not asserted.
    assign w_cancel  = cancel && (r_credit != '0);
    assign w_vend    = (r_state == ACCEPT) && !w_cancel && (w_eff >= PRICE_S);

    vend_drop_timer #(
        .DROP_CYCLES (DROP_CYCLES)
    ) u_drop_timer (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_vend),
        .o_done_c (w_timer_done)
    );

    // Controller state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ACCEPT;
            r_credit        <= '0;
            r_refund_amount <= '0;
            r_drop          <= 1'b0;
            r_coin_reject   <= 1'b0;
            r_refund_valid  <= 1'b0;
            r_vend_count    <= '0;
        end else begin
            r_coin_reject <= 1'b0;
            case (r_state)
                ACCEPT: begin
                    if (w_cancel) begin
                        r_state         <= REFUND;
                        r_refund_valid  <= 1'b1;
                        r_refund_amount <= r_credit;
                        r_coin_reject   <= w_sampled;
                    end else begin
                        r_coin_reject <= w_over;
                        if (w_vend) begin
                            r_state      <= VEND;
                            r_drop       <= 1'b1;
                            r_credit     <= CREDIT_W'(w_eff - PRICE_S);
                            r_vend_count <= r_vend_count + COUNT_W'(1);
                        end else begin
                            r_credit <= CREDIT_W'(w_eff);
                        end
                    end
                end
                VEND: begin
                    r_coin_reject <= w_sampled;
                    if (w_timer_done) begin
                        r_state <= ACCEPT;
                        r_drop  <= 1'b0;
                    end
                end
                REFUND: begin
                    r_coin_reject <= w_sampled;
                    if (refund_ack) begin
                        r_state         <= ACCEPT;
                        r_refund_valid  <= 1'b0;
                        r_refund_amount <= '0;
                        r_credit        <= '0;
                    end
                end
                default: begin
                    r_state <= ACCEPT;
                end
            endcase
        end
    end

    assign credit        = r_credit;
    assign drop          = r_drop;
    assign coin_reject   = r_coin_reject;
    assign refund_valid  = r_refund_valid;
    assign refund_amount = r_refund_amount;
    assign vend_count    = r_vend_count;

endmodule
